// File: rtl/spi_device_rx.sv
// SPI peripheral receiver: oversamples SCLK/nCS/SDI in the clk_i domain,
// deserialises MSB-first bytes and queues them in a small valid/ready FIFO.
//
// state | meaning
// IDLE  | waiting for a synchronised nCS falling edge, bit counter held at 0
// RECV  | inside an nCS-low window, shifting one bit per sample edge
module spi_device_rx #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CPOL          = 1,
  parameter int SAMPLE_RISING = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            SCLK_i,
  input  logic                            nCS_i,
  input  logic                            SDI_i,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     rx_level_o,
  output logic                            busy_o,
  output logic                            overflow_o,
  output logic                            frame_err_o,
  input  logic                            clr_err_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam logic SCLK_IDLE = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, sdi_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      ncs_sync_q  <= '1;
      sdi_sync_q  <= '1;
      sclk_hist_q <= SCLK_IDLE;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SDI_i};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, sdi_s;
  logic sample_edge, ncs_fall, ncs_rise;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  // SDI leaves the chain at the same depth as SCLK, so it is the bit the host set up
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign sample_edge = (SAMPLE_RISING != 0) ? (sclk_s & ~sclk_hist_q)
                                            : (~sclk_s & sclk_hist_q);
  assign ncs_fall    = ~ncs_s & ncs_hist_q;
  assign ncs_rise    = ncs_s & ~ncs_hist_q;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] push_data;
  logic       push, frame_set;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    push_data = {shift_q[6:0], sdi_s};
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (ncs_fall) state_d = RECV;
      end
      RECV: begin
        if (ncs_rise) begin
          state_d   = IDLE;
          frame_set = (bit_cnt_q != 3'd0);
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (sample_edge && !ncs_s) begin
          shift_d = push_data;
          if (bit_cnt_q == 3'd7) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level;
  logic        full, empty, pop, wr_en, ovf_set;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = ~empty & rx_ready_i;
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  logic ovf_q, ferr_q;

  // A set in the same cycle as a clear leaves the flag high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= (ovf_q & ~clr_err_i) | ovf_set;
      ferr_q <= (ferr_q & ~clr_err_i) | frame_set;
    end
  end

  assign rx_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid_o  = ~empty;
  assign rx_level_o  = level;
  assign busy_o      = ~ncs_s;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_spi_device_rx.sv
// Directed bench for spi_device_rx: host-timed SPI frames in, scoreboard
// queue of expected bytes popped by an independent monitor on each beat.
module tb_spi_device_rx;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       SCLK_i = 1'b1;
  logic       nCS_i = 1'b1;
  logic       SDI_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic [2:0] rx_level_o;
  logic       busy_o, overflow_o, frame_err_o;
  logic       clr_err_i = 1'b0;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  logic [7:0] exp_q[$];

  spi_device_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .CPOL(1), .SAMPLE_RISING(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .SCLK_i(SCLK_i), .nCS_i(nCS_i), .SDI_i(SDI_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_level_o(rx_level_o), .busy_o(busy_o), .overflow_o(overflow_o),
    .frame_err_o(frame_err_o), .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every accepted beat must match the oldest expected byte
  always @(negedge clk_i) begin
    if (rx_valid_o) valid_cnt++;
    if (rst_ni && rx_valid_o && rx_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got %02h required none", rx_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data_o !== e) begin
          bad++;
          $display("FAIL beat_data: got %02h required %02h", rx_data_o, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cs_low();
    nCS_i = 1'b0;
    repeat (5) tick();
  endtask

  task automatic cs_high();
    repeat (3) tick();
    nCS_i = 1'b1;
    repeat (6) tick();
  endtask

  // Host timing: SDO changes at SCLK fall, 5 cycles low, 5 cycles high
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit pulse_last);
    for (int i = 0; i < nbits; i++) begin
      SCLK_i = 1'b0;
      SDI_i  = b[7-i];
      repeat (5) tick();
      SCLK_i = 1'b1;
      if (pulse_last && i == nbits - 1) begin
        tick();
        tick();
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        tick();
        tick();
      end else begin
        repeat (5) tick();
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !rx_valid_o) break;
      tick();
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("reset_valid", rx_valid_o, 0);
    chk("reset_level", rx_level_o, 0);
    chk("reset_data", rx_data_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_flags", {overflow_o, frame_err_o}, 0);
    rst_ni = 1'b1;
    repeat (3) tick();

    // Single byte, consumer always ready
    rx_ready_i = 1'b1;
    valid_cnt = 0;
    exp_q.push_back(8'hA5);
    cs_low();
    chk("busy_in_frame", busy_o, 1);
    send_bits(8'hA5, 8, 1'b0);
    cs_high();
    wait_drain("single_drain");
    chk("single_valid_cycles", valid_cnt, 1);
    chk("single_flags", {overflow_o, frame_err_o}, 0);

    // Four bytes under backpressure
    rx_ready_i = 1'b0;
    cs_low();
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      send_bits(8'(k), 8, 1'b0);
    end
    cs_high();
    chk("multi_level", rx_level_o, 4);
    chk("multi_ovf", overflow_o, 0);
    rx_ready_i = 1'b1;
    wait_drain("multi_drain");
    chk("multi_level_empty", rx_level_o, 0);

    // Overflow: fifth byte dropped
    rx_ready_i = 1'b0;
    cs_low();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(8'h10 + 8'(k));
      send_bits(8'h10 + 8'(k), 8, 1'b0);
    end
    cs_high();
    chk("ovf_set", overflow_o, 1);
    chk("ovf_level", rx_level_o, 4);
    rx_ready_i = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", overflow_o, 1);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    chk("ovf_clear", overflow_o, 0);

    // Full FIFO, pop in the same cycle as the push of 0x55
    rx_ready_i = 1'b0;
    cs_low();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h21 + 8'(k));
      send_bits(8'h21 + 8'(k), 8, 1'b0);
    end
    exp_q.push_back(8'h55);
    send_bits(8'h55, 8, 1'b1);
    cs_high();
    chk("full_pp_ovf", overflow_o, 0);
    chk("full_pp_level", rx_level_o, 4);
    chk("full_pp_pending", exp_q.size(), 4);
    rx_ready_i = 1'b1;
    wait_drain("full_pp_drain");

    // Truncated frame, then a good one
    cs_low();
    send_bits(8'hFF, 5, 1'b0);
    cs_high();
    chk("trunc_ferr", frame_err_o, 1);
    chk("trunc_level", rx_level_o, 0);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    chk("trunc_clear", frame_err_o, 0);
    exp_q.push_back(8'h3C);
    cs_low();
    send_bits(8'h3C, 8, 1'b0);
    cs_high();
    wait_drain("trunc_next_drain");
    chk("trunc_next_ferr", frame_err_o, 0);

    // Reset in the middle of a byte
    cs_low();
    send_bits(8'hFF, 3, 1'b0);
    rst_ni = 1'b0;
    repeat (3) tick();
    nCS_i = 1'b1;
    SCLK_i = 1'b1;
    tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    chk("rst_mid_flags", {overflow_o, frame_err_o}, 0);
    chk("rst_mid_level", rx_level_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    exp_q.push_back(8'hC3);
    cs_low();
    send_bits(8'hC3, 8, 1'b0);
    cs_high();
    wait_drain("rst_mid_drain");
    chk("rst_mid_flags_after", {overflow_o, frame_err_o}, 0);

    // SCLK activity while deselected must not push
    valid_cnt = 0;
    send_bits(8'h00, 8, 1'b0);
    repeat (5) tick();
    chk("glitch_valid_cycles", valid_cnt, 0);
    chk("glitch_level", rx_level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_device_rx.md
Name: spi_device_rx

Overview:
- SPI peripheral-side receiver: the far end of the team's transmit-only SPI host link (nCS active-low, SCLK idles high, MSB first, SDO changes after the SCLK falling edge).
- Oversamples SCLK/nCS/SDI in the clk_i domain, deserialises bytes and queues them in a small FIFO with a valid/ready output.
- Flags overflow and truncated frames.
- Used as a loopback/bench peer for the host and as an on-chip SPI command sink.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on SCLK_i, nCS_i, SDI_i; ≥2.
- CPOL, 1: SCLK idle level; reset value of the SCLK synchroniser.
- SAMPLE_RISING, 1: 1 = sample SDI on SCLK rising edge, 0 = on falling edge.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset.
- SCLK_i  in  1  SPI clock from host, asynchronous.
- nCS_i  in  1  chip select, active-low, asynchronous.
- SDI_i  in  1  serial data from host, asynchronous.
- rx_data_o  out  8  FIFO head byte.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts head byte.
- rx_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy_o  out  1  synchronised nCS low.
- overflow_o  out  1  sticky: byte dropped, FIFO full.
- frame_err_o  out  1  sticky: nCS rose mid-byte.
- clr_err_i  in  1  clears both sticky flags.

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values:
  - SCLK sync chain = CPOL; nCS sync chain = 1; SDI sync chain = 1.
  - bit_cnt = 0, shift = 0, FIFO empty.
  - rx_valid_o = 0, rx_level_o = 0, rx_data_o = 0, busy_o = 0, overflow_o = 0, frame_err_o = 0.
- Synchronisation:
  - All three inputs pass through SYNC_STAGES flops, then one extra history flop on SCLK and nCS.
  - SDI is delayed identically so it stays aligned with SCLK.
  - Edges are detected from last sync stage vs history flop.
- Input timing requirement: SCLK high and low each ≥ SYNC_STAGES+1 clk_i cycles. The host's 10-cycle SCLK (5 high / 5 low) complies.
- FSM:
  - IDLE: bit_cnt = 0. Synchronised nCS falling edge → RECV.
  - RECV, sample edge: on the synchronised sample edge while synced nCS = 0, shift <= {shift[6:0], sdi_sync} and bit_cnt++.
  - RECV, 8th sample: the same cycle writes {shift[6:0], sdi_sync} to the FIFO, and bit_cnt <= 0.
  - RECV, nCS rise: synchronised nCS rising edge → IDLE. If bit_cnt ≠ 0, set frame_err_o and discard partial shift contents.
- Gating:
  - Sample edges while synced nCS = 1 are ignored.
  - Opposite-polarity SCLK edges are ignored.
- Latency: pin SCLK edge → shift update after SYNC_STAGES+1 clk_i edges. FIFO write on the 8th sample → rx_valid_o high on the next clk_i edge.
- FIFO:
  - Registered pointers; rx_data_o shows the head entry.
  - Pop occurs when rx_valid_o & rx_ready_i.
  - rx_ready_i while empty is ignored.
  - Push while full without a same-cycle pop: byte dropped, overflow_o <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow, level unchanged.
  - Push and pop in the same cycle with level 1: level stays 1, rx_data_o shows the new byte.
  - Pointers wrap modulo FIFO_DEPTH; level spans 0..FIFO_DEPTH.
- Multi-byte frames: bytes received under one nCS-low window are each pushed. No error when nCS rises with bit_cnt = 0.
- Sticky flags: clr_err_i clears both. A set event in the same cycle as clr_err_i wins (flag stays 1).
- Reset mid-frame: everything returns to reset values immediately. A frame in progress is lost, with no flags set. After reset release the block waits for a fresh nCS falling edge.

Test Plan:
- Single byte: host-timed frame with 0xA5, 10-cycle SCLK, rx_ready_i = 1 → one beat rx_data_o = 0xA5; rx_valid_o high for exactly 1 cycle; no flags.
- Multi-byte with backpressure: 0x01, 0x02, 0x03, 0x04 in one nCS window, rx_ready_i = 0 → rx_level_o = 4; then drained in order 01, 02, 03, 04; overflow_o = 0.
- Overflow: 5 bytes 0x10..0x14 with rx_ready_i = 0, FIFO_DEPTH = 4 → overflow_o = 1; FIFO holds 10..13; clr_err_i pulse → overflow_o = 0.
- Full push+pop: FIFO full, rx_ready_i pulsed in the 8th-sample cycle of 0x55 → no overflow; level stays 4; 0x55 is the last byte out.
- Truncated frame: nCS rises after 5 bits → frame_err_o = 1, nothing pushed. Next full frame 0x3C is received correctly.
- Reset mid-byte: rst_ni low after 3 bits, then a full 0xC3 frame → only 0xC3 delivered, flags 0; SCLK glitch while nCS high → no push.
